// File: rtl/cpu_pkg.sv
// cpu_pkg
// Shared definitions for the CPU pipeline stages.
//   PC_W, INSTR_W    default program-counter and instruction widths
//   IMEM_FILL_BASE   word i of the built-in instruction image holds i + this value
//   if_state_t       fetch-stage sequencing states (BOOT / RUN / REDIRECT)
//   jump_type_t      redirect kinds reported by the memory/writeback stage
package cpu_pkg;

   localparam int PC_W           = 5;
   localparam int INSTR_W        = 32;
   localparam int IMEM_FILL_BASE = 100;

   typedef enum logic [1:0] {
      BOOT     = 2'd0,
      RUN      = 2'd1,
      REDIRECT = 2'd2
   } if_state_t;

   typedef enum logic [1:0] {
      JT_NONE   = 2'd0,
      JT_JAL    = 2'd1,
      JT_JALR   = 2'd2,
      JT_BRANCH = 2'd3
   } jump_type_t;

endpackage

// File: rtl/imem.sv
// imem
// Synchronous-read instruction ROM with one cycle of read latency.
// The contents are a built-in image in which word i holds
// i + IMEM_FILL_BASE; INIT_FILE is accepted for interface compatibility.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset, clears the read register
//   en     read enable; when low the read register holds its value
//   addr   word address (depth 2**PC_W)
//   rdata  registered read data, valid the cycle after addr is presented
module imem #(
   parameter int PC_W      = cpu_pkg::PC_W,
   parameter int INSTR_W   = cpu_pkg::INSTR_W,
   parameter     INIT_FILE = ""
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [PC_W-1:0]    addr,
   output logic [INSTR_W-1:0] rdata
);

   import cpu_pkg::*;

   // Registered read of the built-in image, which is a pure function of
   // the address, so no storage array is needed. The read register holds
   // while en is low so a stalled fetch keeps presenting the same word.
   always_ff @(posedge clk) begin
      if (rst) begin
         rdata <= '0;
      end else if (en) begin
         rdata <= INSTR_W'(addr) + INSTR_W'(IMEM_FILL_BASE);
      end
   end

endmodule

// File: rtl/if_stage.sv
// if_stage
// Instruction fetch stage: keeps the PC, issues one ROM read per cycle
// and presents the fetched word with its address one cycle later.
// Redirects from the memory/writeback stage squash the in-flight fetch
// and cost one bubble; stall freezes the whole stage.
// Optional feature: define IF_PERF_CNT_EN to add the fetch_cnt and
// squash_cnt performance counters and their ports.
// Ports:
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   should_jump  redirect request
//   jump_target  redirect PC, used when should_jump=1
//   stall        decode not ready, hold fetch
//   instr        fetched instruction word
//   pc_out       address of instr
//   pc_plus1     pc_out + 1 (link value)
//   instr_valid  instr / pc_out are meaningful this cycle
//   fetch_cnt    (IF_PERF_CNT_EN) cycles with instr_valid=1 and stall=0
//   squash_cnt   (IF_PERF_CNT_EN) squashed in-flight fetches
module if_stage #(
   parameter int              PC_W      = cpu_pkg::PC_W,
   parameter int              INSTR_W   = cpu_pkg::INSTR_W,
   parameter logic [PC_W-1:0] BOOT_PC   = '0,
   parameter                  IMEM_FILE = ""
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               should_jump,
   input  logic [PC_W-1:0]    jump_target,
   input  logic               stall,
   output logic [INSTR_W-1:0] instr,
   output logic [PC_W-1:0]    pc_out,
   output logic [PC_W-1:0]    pc_plus1,
   output logic               instr_valid
`ifdef IF_PERF_CNT_EN
   ,
   output logic [15:0]        fetch_cnt,
   output logic [15:0]        squash_cnt
`endif
);

   import cpu_pkg::*;

   if_state_t       state;
   if_state_t       state_next;
   logic [PC_W-1:0] pc;
   logic [PC_W-1:0] pc_next;
   logic            advance;
   logic            valid_next;

   // Next-state logic. A redirect wins over stall: it loads the target and
   // marks the word being fetched now as invalid. Without a redirect, stall
   // freezes everything (advance=0). BOOT issues a throwaway fetch at the
   // boot PC and does not move the PC, so the first valid word appears two
   // cycles after reset release. RUN and REDIRECT both fetch at pc, step
   // the PC and mark the resulting word valid; the REDIRECT bubble comes
   // from the invalid word captured on the redirect cycle itself.
   always_comb begin
      state_next = state;
      pc_next    = pc;
      advance    = 1'b0;
      valid_next = instr_valid;
      if (should_jump) begin
         state_next = REDIRECT;
         pc_next    = jump_target;
         advance    = 1'b1;
         valid_next = 1'b0;
      end else if (!stall) begin
         advance = 1'b1;
         unique case (state)
            BOOT: begin
               state_next = RUN;
               valid_next = 1'b0;
            end
            RUN, REDIRECT: begin
               state_next = RUN;
               pc_next    = pc + PC_W'(1);
               valid_next = 1'b1;
            end
            default: begin
               state_next = BOOT;
               valid_next = 1'b0;
            end
         endcase
      end
   end

   // State, PC and output registers. The address/link registers capture
   // the fetch address alongside the ROM read so they line up with instr.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= BOOT;
         pc          <= BOOT_PC;
         pc_out      <= '0;
         pc_plus1    <= '0;
         instr_valid <= 1'b0;
      end else begin
         state       <= state_next;
         pc          <= pc_next;
         instr_valid <= valid_next;
         if (advance) begin
            pc_out   <= pc;
            pc_plus1 <= pc + PC_W'(1);
         end
      end
   end

   imem #(
      .PC_W      (PC_W),
      .INSTR_W   (INSTR_W),
      .INIT_FILE (IMEM_FILE)
   ) u_imem (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .addr  (pc),
      .rdata (instr)
   );

`ifdef IF_PERF_CNT_EN
   // Saturating performance counters. A word is consumed when it is valid
   // and decode is not stalling; every redirect cycle throws away the
   // fetch issued in that cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_cnt  <= '0;
         squash_cnt <= '0;
      end else begin
         if (instr_valid && !stall && fetch_cnt != 16'hFFFF) begin
            fetch_cnt <= fetch_cnt + 16'd1;
         end
         if (should_jump && squash_cnt != 16'hFFFF) begin
            squash_cnt <= squash_cnt + 16'd1;
         end
      end
   end
`endif

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter PC_W, default 5, program counter width; instruction memory depth is 2**PC_W words.
REQ-002 Parameter INSTR_W, default 32, instruction word width.
REQ-003 Parameter BOOT_PC, default 0, PC value loaded on reset.
REQ-004 One clock; reset is synchronous and active-high.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 should_jump  input  1  redirect request from the memory/writeback stage.
REQ-008 jump_target  input  PC_W  redirect PC, valid when should_jump=1.
REQ-009 stall  input  1  decode not ready; hold fetch.
REQ-010 instr  output  INSTR_W  fetched instruction word.
REQ-011 pc_out  output  PC_W  address of instr.
REQ-012 pc_plus1  output  PC_W  pc_out+1 mod 2**PC_W, the link value for jumps.
REQ-013 instr_valid  output  1  instr/pc_out are meaningful this cycle.

Function
REQ-014 States: BOOT, RUN, REDIRECT; all outputs registered.
REQ-015 BOOT: fetch issued at pc; instr_valid=0; next state RUN.
REQ-016 RUN with no stall and no should_jump: pc <= pc+1, wrapping 2**PC_W-1 -> 0; instr_valid=1 for the word issued the previous cycle.
REQ-017 ROM read latency is exactly 1 cycle: the address issued at cycle N gives instr and pc_out at cycle N+1.
REQ-018 should_jump=1 in any state: pc <= jump_target; the in-flight fetch is squashed; next state REDIRECT.
REQ-019 REDIRECT: instr_valid=0 (one bubble); the fetch at jump_target is issued; next state RUN.
REQ-020 should_jump has priority over stall; a redirect during stall is taken and discards the held instr.
REQ-021 stall=1 without should_jump: pc, ROM address, instr, pc_out, pc_plus1 and instr_valid hold their values; the state is unchanged.
REQ-022 Back-to-back should_jump on consecutive cycles: the last target wins; instr_valid stays 0 until one cycle after should_jump deasserts.
REQ-023 jump_target equal to the current pc is legal and behaves as a normal redirect.

Reset
REQ-024 rst overrides should_jump and stall.
REQ-025 On rst: pc=BOOT_PC, instr=0, pc_out=0, pc_plus1=0, instr_valid=0, state=BOOT.
REQ-026 Reset asserted mid-stream or mid-redirect drops all in-flight fetches; the first valid instruction after reset release is at BOOT_PC, two cycles after release.

Configuration
REQ-027 Macro IF_PERF_CNT_EN.
REQ-028 Defined: adds outputs fetch_cnt (16 bits, counts cycles with instr_valid=1 and stall=0) and squash_cnt (16 bits, counts squashed in-flight fetches); both saturate at 16'hFFFF and reset to 0.
REQ-029 Undefined: neither counter nor its ports exist; all other behaviour is identical.

Structure
REQ-030 Shared package cpu_pkg holds PC_W, INSTR_W, the state enum typedef (BOOT/RUN/REDIRECT) and the jump_type encodings shared with the memory/writeback stage.
REQ-031 One sub-module, imem: a synchronous-read ROM of depth 2**PC_W with 1-cycle latency, initialised from a hex file and instantiated once.

Verification
REQ-032 Reset release, ROM[i]=i+100, no stall -> instr_valid rises on cycle 2; pc_out=0,1,2 with instr=100,101,102 on consecutive cycles.
REQ-033 Free-run across wrap -> pc_out 31 followed by 0, and pc_plus1=0 when pc_out=31.
REQ-034 should_jump=1, target=7, while pc_out=3 -> next cycle instr_valid=0; the following cycle pc_out=7, instr=ROM[7], pc_plus1=8.
REQ-035 stall high for 3 cycles at pc_out=5 -> all outputs frozen at 5/ROM[5]; pc_out=6 on the cycle after stall drops.
REQ-036 stall=1 and should_jump=1 (target=20) together -> redirect taken, one bubble, then pc_out=20.
REQ-037 rst pulsed during REDIRECT -> instr_valid=0, pc_out=0 the next cycle; the target is discarded; with IF_PERF_CNT_EN defined, both counters read 0.
